// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding read per instruction, then it holds
// the word for decode until the datapath retires it. A misaligned next PC halts the unit.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc,
    input  logic        pc_update,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        instr_valid,
    output logic        misalign,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        VALID = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_req;
    logic        r_valid;
    logic        r_misalign;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_retired;
    logic        w_bad_target;

    assign w_bad_target = (next_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= FETCH;
            r_req      <= 1'b1;
            r_valid    <= 1'b0;
            r_misalign <= 1'b0;
            r_pc       <= RESET_PC;
            r_instr    <= 32'h0;
            r_retired  <= 32'h0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (imem_ack) begin
                        r_instr <= imem_rdata;
                        r_valid <= 1'b1;
                        r_req   <= 1'b0;
                        r_state <= VALID;
                    end
                end
                VALID: begin
                    if (pc_update) begin
                        r_pc      <= next_pc;
                        r_valid   <= 1'b0;
                        r_retired <= r_retired + 32'd1;
                        if (w_bad_target) begin
                            // Fault is sticky: nothing but reset leaves HALT.
                            r_misalign <= 1'b1;
                            r_req      <= 1'b0;
                            r_state    <= HALT;
                        end else begin
                            r_req   <= 1'b1;
                            r_state <= FETCH;
                        end
                    end
                end
                HALT: begin
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
                default: begin
                    r_state <= HALT;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // Address always reflects pc; imem_req alone says whether a read is live.
    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign pc          = r_pc;
    assign pc4         = r_pc + 32'd4;
    assign instr_valid = r_valid;
    assign misalign    = r_misalign;
    assign retired     = r_retired;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: handshake, latency, retire, misalign halt,
// reset priority and 32-bit wrap of pc4 and the retire counter.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] next_pc;
    logic        pc_update;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        instr_valid;
    logic        misalign;
    logic [31:0] retired;

    int total = 0;
    int bad   = 0;

    fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk        (clk),
        .reset      (reset),
        .next_pc    (next_pc),
        .pc_update  (pc_update),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .pc         (pc),
        .pc4        (pc4),
        .instr_valid(instr_valid),
        .misalign   (misalign),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        next_pc    = 32'h0;
        pc_update  = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        tick();
        reset = 1'b0;

        // reset state
        chk("rst_pc",    pc, 32'h0000_3000);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_mis",   {31'b0, misalign}, 32'd0);
        chk("rst_ret",   retired, 32'd0);
        chk("rst_req",   {31'b0, imem_req}, 32'd1);
        chk("rst_addr",  imem_addr, 32'h0000_3000);

        // ack in the first FETCH cycle
        imem_ack = 1'b1; imem_rdata = 32'h2408_0005;
        tick();
        imem_ack = 1'b0;
        chk("f1_instr", instr, 32'h2408_0005);
        chk("f1_pc",    pc, 32'h0000_3000);
        chk("f1_pc4",   pc4, 32'h0000_3004);
        chk("f1_valid", {31'b0, instr_valid}, 32'd1);
        chk("f1_req",   {31'b0, imem_req}, 32'd0);

        // ack while VALID must be ignored
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        chk("v_ackign", instr, 32'h2408_0005);
        chk("v_hold",   {31'b0, instr_valid}, 32'd1);

        // aligned retire
        pc_update = 1'b1; next_pc = 32'h0000_3010;
        tick();
        pc_update = 1'b0;
        chk("u_pc",    pc, 32'h0000_3010);
        chk("u_valid", {31'b0, instr_valid}, 32'd0);
        chk("u_ret",   retired, 32'd1);
        chk("u_req",   {31'b0, imem_req}, 32'd1);
        chk("u_addr",  imem_addr, 32'h0000_3010);

        // delayed ack after a fresh reset; pc_update in FETCH is ignored
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pc_update = 1'b1; next_pc = 32'h0000_4000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("d_req",   {31'b0, imem_req}, 32'd1);
            chk("d_addr",  imem_addr, 32'h0000_3000);
            chk("d_valid", {31'b0, instr_valid}, 32'd0);
            chk("d_ret",   retired, 32'd0);
        end
        pc_update = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h8C09_0004;
        tick();
        imem_ack = 1'b0;
        chk("d_instr", instr, 32'h8C09_0004);
        chk("d_vld1",  {31'b0, instr_valid}, 32'd1);

        // pc wrap boundary for pc4
        pc_update = 1'b1; next_pc = 32'hFFFF_FFFC;
        tick();
        pc_update = 1'b0;
        chk("w_pc",  pc, 32'hFFFF_FFFC);
        chk("w_pc4", pc4, 32'h0000_0000);
        chk("w_ret", retired, 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'h0000_0001;
        tick();
        imem_ack = 1'b0;
        chk("w_vld", {31'b0, instr_valid}, 32'd1);

        // retire counter wrap: preload the counter at all-ones
        force dut.r_retired = 32'hFFFF_FFFF;
        #1;
        release dut.r_retired;
        pc_update = 1'b1; next_pc = 32'h0000_3000;
        tick();
        pc_update = 1'b0;
        chk("r_wrap", retired, 32'd0);
        chk("r_pc",   pc, 32'h0000_3000);
        chk("r_req",  {31'b0, imem_req}, 32'd1);

        // misaligned target halts
        imem_ack = 1'b1; imem_rdata = 32'h0000_0002;
        tick();
        imem_ack = 1'b0;
        pc_update = 1'b1; next_pc = 32'h0000_3002;
        tick();
        chk("m_mis",   {31'b0, misalign}, 32'd1);
        chk("m_pc",    pc, 32'h0000_3002);
        chk("m_valid", {31'b0, instr_valid}, 32'd0);
        chk("m_req",   {31'b0, imem_req}, 32'd0);
        chk("m_ret",   retired, 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678; next_pc = 32'h0000_5000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("h_req",   {31'b0, imem_req}, 32'd0);
            chk("h_pc",    pc, 32'h0000_3002);
            chk("h_ret",   retired, 32'd1);
            chk("h_valid", {31'b0, instr_valid}, 32'd0);
            chk("h_mis",   {31'b0, misalign}, 32'd1);
        end
        pc_update = 1'b0;

        // reset wins over a same-cycle ack in FETCH
        reset = 1'b1;
        tick();
        reset = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        imem_ack = 1'b0;
        chk("x_instr", instr, 32'h0);
        chk("x_valid", {31'b0, instr_valid}, 32'd0);
        chk("x_pc",    pc, 32'h0000_3000);
        chk("x_mis",   {31'b0, misalign}, 32'd0);
        tick();
        chk("x_req",   {31'b0, imem_req}, 32'd1);
        chk("x_vld2",  {31'b0, instr_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
